// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register bank with byte strobes, a read-only mask and
// SLVERR on out-of-range or read-only writes. Register contents are exported
// flat on reg_q. Write address and write data may arrive in either order.
module axil_slave_regfile #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [WIDTH/8-1:0]        wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [WIDTH-1:0]          rdata,
  output logic [1:0]                rresp,
  output logic [NUM_REGS*WIDTH-1:0] reg_q
);

  localparam int STRB_W = WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [WIDTH-1:0]  regs [NUM_REGS];
  logic              ready_en;
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [WIDTH-1:0]  w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_REGS-1:0] w_sel;
  logic              w_ok;
  logic              r_hit;
  logic [WIDTH-1:0]  rd_val;
  logic              commit;
  logic              unused_addr_bits;

  // The byte-offset bits never take part in decoding.
  assign unused_addr_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

  assign r_idx   = araddr[ADDR_WIDTH-1:OFF_W];
  assign commit  = aw_held && w_held;
  assign awready = ready_en && !aw_held && !bvalid;
  assign wready  = ready_en && !w_held && !bvalid;
  assign arready = ready_en && !rvalid;

  // Readies stay low through reset and rise on the first edge out of it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of block ordering.
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Decode held write index and incoming read index against the bank.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_sel  = '0;
    w_ok   = 1'b0;
    r_hit  = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i)) begin
        w_sel[i] = 1'b1;
        w_ok     = !RO_MASK[i];
      end
      if (r_idx == IDX_W'(i)) begin
        r_hit  = 1'b1;
        rd_val = regs[i];
      end
    end
  end

  // Write channel: hold AW and W independently, commit once both are held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_idx_q <= awaddr[ADDR_WIDTH-1:OFF_W];
        aw_held  <= 1'b1;
      end
      if (wvalid && wready) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        w_held   <= 1'b1;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register bank: byte-lane update of the addressed writable register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the bank is built from flops, not RAM, so it can and must be
      // cleared by reset; a RAM-based bank could not be reset this way.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_sel[i] && !RO_MASK[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs[i][8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: capture data at the AR handshake, hold until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= r_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  // Flat export of the register bank.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*WIDTH +: WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile (32-bit, 8 registers, reg0 read-only).
module tb_axil_slave_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [7:0]   awaddr, araddr;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] reg_q;

  logic [31:0]  exp_regs [8];
  int           n_cmp = 0;
  int           n_err = 0;

  axil_slave_regfile #(
    .WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8), .RO_MASK(8'h01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_reg%0d", tag, i), 64'(reg_q[i*32 +: 32]), 64'(exp_regs[i]));
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int   n;
    logic aw_done, w_done, a_hs, w_hs;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      tick();
      if (a_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
      n++;
    end
    check("wr_handshake", 64'({aw_done, w_done}), 64'd3);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", 64'(bvalid), 64'd1);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int   n;
    logic done, hs;
    arvalid = 1'b1; araddr = a; done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      hs = arvalid && arready;
      tick();
      if (hs) begin done = 1'b1; arvalid = 1'b0; end
      n++;
    end
    arvalid = 1'b0;
    check("rd_handshake", 64'(rvalid), 64'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;

    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check_regs("rst");
    rst_n = 1'b1;
    tick();
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_wready",  64'(wready),  64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // AW and W together: bvalid exactly one cycle after the handshake edge
    awvalid = 1'b1; awaddr = 8'h04; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_bvalid_early", 64'(bvalid),  64'd0);
    check("t1_awready_held", 64'(awready), 64'd0);
    tick();
    exp_regs[1] = 32'hDEADBEEF;
    check("t1_bvalid", 64'(bvalid), 64'd1);
    check("t1_bresp",  64'(bresp),  64'd0);
    check_regs("t1");
    bready = 1'b1; tick(); bready = 1'b0;
    check("t1_bvalid_clr", 64'(bvalid), 64'd0);
    axi_read(8'h04, d, resp);
    check("t1_rdata", 64'(d), 64'hDEADBEEF);
    check("t1_rresp", 64'(resp), 64'd0);

    // W three cycles ahead of AW, sparse strobes over all-ones
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, resp);
    exp_regs[2] = 32'hFFFFFFFF;
    check("t2_pre_bresp", 64'(resp), 64'd0);
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'b0101;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_low", 64'(wready), 64'd0);
      check("t2_no_bvalid",  64'(bvalid), 64'd0);
      if (i < 2) tick();
    end
    awvalid = 1'b1; awaddr = 8'h08;
    tick();
    awvalid = 1'b0;
    check("t2_bvalid_early", 64'(bvalid), 64'd0);
    check("t2_wready_held",  64'(wready), 64'd0);
    tick();
    exp_regs[2] = 32'hFF34FF78;
    check("t2_bvalid", 64'(bvalid), 64'd1);
    check("t2_bresp",  64'(bresp),  64'd0);
    check_regs("t2");
    bready = 1'b1; tick(); bready = 1'b0;

    // Byte offset ignored on read; zero strobe is OKAY with no change
    axi_read(8'h0B, d, resp);
    check("off_rdata", 64'(d), 64'hFF34FF78);
    axi_write(8'h08, 32'h00000000, 4'h0, resp);
    check("strb0_bresp", 64'(resp), 64'd0);
    check_regs("strb0");

    // Out of range index 8
    axi_write(8'h20, 32'hCAFEF00D, 4'hF, resp);
    check("oor_bresp", 64'(resp), 64'd2);
    check_regs("oor");
    axi_read(8'h20, d, resp);
    check("oor_rdata", 64'(d), 64'd0);
    check("oor_rresp", 64'(resp), 64'd2);

    // Read-only register 0
    axi_write(8'h00, 32'hA5A5A5A5, 4'hF, resp);
    check("ro_bresp", 64'(resp), 64'd2);
    check_regs("ro");
    axi_read(8'h00, d, resp);
    check("ro_rdata", 64'(d), 64'd0);
    check("ro_rresp", 64'(resp), 64'd0);

    // Write response backpressure
    awvalid = 1'b1; awaddr = 8'h0C; wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    exp_regs[3] = 32'h11223344;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid",  64'(bvalid),  64'd1);
      check("bp_bresp",   64'(bresp),   64'd0);
      check("bp_awready", 64'(awready), 64'd0);
      check("bp_wready",  64'(wready),  64'd0);
      tick();
    end
    bready = 1'b1; tick(); bready = 1'b0;
    check("bp_bvalid_clr", 64'(bvalid),  64'd0);
    check("bp_awready_up", 64'(awready), 64'd1);

    // Read data backpressure
    arvalid = 1'b1; araddr = 8'h0C;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rbp_rvalid",  64'(rvalid),  64'd1);
      check("rbp_rdata",   64'(rdata),   64'h11223344);
      check("rbp_arready", 64'(arready), 64'd0);
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    check("rbp_rvalid_clr", 64'(rvalid),  64'd0);
    check("rbp_arready_up", 64'(arready), 64'd1);

    // Read and write commit on the same edge: read sees the old value
    awvalid = 1'b1; awaddr = 8'h0C; wvalid = 1'b1; wdata = 32'h55667788; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 8'h0C;
    tick();
    arvalid = 1'b0;
    exp_regs[3] = 32'h55667788;
    check("raw_bvalid", 64'(bvalid), 64'd1);
    check("raw_rvalid", 64'(rvalid), 64'd1);
    check("raw_rdata",  64'(rdata),  64'h11223344);
    check_regs("raw");
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;

    // Reset mid-transaction with AW held and rvalid high
    awvalid = 1'b1; awaddr = 8'h10;
    arvalid = 1'b1; araddr = 8'h04;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("mrst_rvalid_pre",   64'(rvalid),  64'd1);
    check("mrst_awready_pre",  64'(awready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;
    check("mrst_bvalid",  64'(bvalid),  64'd0);
    check("mrst_rvalid",  64'(rvalid),  64'd0);
    check("mrst_awready", 64'(awready), 64'd0);
    check_regs("mrst");
    tick();
    check("mrst_awready_up", 64'(awready), 64'd1);
    check("mrst_wready_up",  64'(wready),  64'd1);
    check("mrst_arready_up", 64'(arready), 64'd1);
    wvalid = 1'b1; wdata = 32'h00000099; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    check("mrst_no_commit", 64'(bvalid), 64'd0);
    check_regs("mrst_w");
    awvalid = 1'b1; awaddr = 8'h14;
    tick();
    awvalid = 1'b0;
    tick();
    exp_regs[5] = 32'h00000099;
    check("mrst_bvalid2", 64'(bvalid), 64'd1);
    check("mrst_bresp2",  64'(bresp),  64'd0);
    check_regs("mrst_c");
    bready = 1'b1; tick(); bready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_slave_regfile.md
Name: axil_slave_regfile

Overview:
Parametrised AXI4-Lite slave with a register bank of configurable width and depth. It accepts write address and write data independently and supports byte strobes. Accesses that are out of range or that write a read-only register return SLVERR. It sits behind the slave_if bus as the generic control/status register block; register contents are exported flat to the surrounding logic.

Parameters:
WIDTH, 32, data width in bits; legal values 32 or 64
ADDR_WIDTH, 8, byte-address width of awaddr/araddr
NUM_REGS, 8, number of WIDTH-bit registers; NUM_REGS*(WIDTH/8) <= 2**ADDR_WIDTH
RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only to the bus

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_WIDTH  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  WIDTH  write data
wstrb  in  WIDTH/8  byte-lane strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response, 00 OKAY / 10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_WIDTH  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  WIDTH  read data
rresp  out  2  read response, 00 OKAY / 10 SLVERR
reg_q  out  NUM_REGS*WIDTH  register contents, reg i at [i*WIDTH +: WIDTH]

Behaviour:
- Reset (rst_n low at an edge): all registers 0; all outputs 0, including every ready; holding flags cleared. The readies go high on the first edge with rst_n high. A reset mid-transaction discards held AW/W and drops bvalid/rvalid on that edge.
- Decode: word index = addr[ADDR_WIDTH-1 : log2(WIDTH/8)]; the low byte-offset bits are ignored. An index >= NUM_REGS is out of range.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held. The two may arrive in either order or in the same cycle.
  - Commit: on the first edge where both held flags are set, the write is performed, both flags clear, bvalid=1 and bresp is set.
  - Latency from the later of the two handshakes to bvalid is 1 cycle.
  - Write action: for each lane b with wstrb[b]=1, reg[idx][8b+:8] = wdata[8b+:8]. wstrb=0 gives OKAY with no change.
  - Out-of-range or RO_MASK[idx]=1: no register changes, bresp=10.
  - bvalid/bresp hold until bready; bvalid clears on the edge with bvalid&&bready. Only one write is outstanding at a time.
- Read channel:
  - arready = !rvalid.
  - An AR handshake at edge N loads rdata/rresp, with rvalid=1 after N.
  - In range: rdata = reg[idx], rresp=00 (read-only registers read OKAY). Out of range: rdata=0, rresp=10.
  - rdata/rresp are stable while rvalid && !rready; rvalid clears on the rvalid&&rready edge.
  - A new AR is accepted only on the cycle after rvalid clears.
- Concurrency:
  - Read and write channels are fully independent.
  - If a read and a write commit target the same register on the same edge, the read returns the pre-write value.
- reg_q reflects register state directly; it updates the cycle after commit.

Test Plan:
- Reset, then AW+W in the same cycle to addr 0x04 with wdata=0xDEADBEEF, wstrb=4'hF -> bvalid one cycle later with bresp=00; reg_q[63:32]=0xDEADBEEF; a read of 0x04 returns 0xDEADBEEF, OKAY.
- W issued 3 cycles before AW (addr 0x08, 0x12345678, wstrb=4'b0101) onto a register holding 0xFFFFFFFF -> wready low after W until commit; reg2=0xFF34FF78.
- Write and read to addr 0x20 (index 8, NUM_REGS=8) -> bresp=10 with no reg_q change; rdata=0 with rresp=10.
- RO_MASK=8'h01; write 0xA5A5A5A5 to 0x00 -> bresp=10 and reg0 stays 0; a read of 0x00 gives OKAY.
- Backpressure: hold bready=0 for 5 cycles and rready=0 for 4 cycles -> bvalid/bresp and rvalid/rdata stay stable; awready/wready/arready stay low until the respective handshakes.
- Assert rst_n=0 for 1 cycle with aw_held set and rvalid high -> bvalid and rvalid are 0 after the edge; registers are 0; readies are high the next cycle; the held address is never committed.
